// File: rtl/alu_cmd_ctrl_pkg.sv
// rtl/alu_cmd_ctrl_pkg.sv - shared state encoding and command bytes for the ALU command controller
package alu_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        ALU_RUN  = 3'd4,
        ALU_WAIT = 3'd5,
        SEND_LO  = 3'd6,
        SEND_HI  = 3'd7
    } state_t;

    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART byte framing FSM that loads ALU operands, fires the ALU and returns the result
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         RX_D,
    input  logic               RX_D_VLD,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [3:0]         ALU_FUN,
    output logic               ALU_en,
    input  logic [2*WIDTH-1:0] ALU_OUT,
    output logic [7:0]         TX_D,
    output logic               TX_D_VLD,
    input  logic               TX_RDY,
    output logic               CMD_ERR
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_nxt, b_nxt;
    logic [3:0]         fun_nxt;
    logic [2*WIDTH-1:0] result, result_nxt;
    logic               err_nxt;

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            A       <= '0;
            B       <= '0;
            ALU_FUN <= '0;
            result  <= '0;
            CMD_ERR <= 1'b0;
        end else begin
            state   <= state_nxt;
            A       <= a_nxt;
            B       <= b_nxt;
            ALU_FUN <= fun_nxt;
            result  <= result_nxt;
            CMD_ERR <= err_nxt;
        end
    end

    // Next-state and register updates; bytes arriving while busy are dropped and flagged
    always_comb begin
        state_nxt  = state;
        a_nxt      = A;
        b_nxt      = B;
        fun_nxt    = ALU_FUN;
        result_nxt = result;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_D == CMD_ALU_OP) begin
                        state_nxt = GET_A;
                    end else if (RX_D == CMD_ALU_NOP) begin
                        state_nxt = GET_FUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    a_nxt     = RX_D[WIDTH-1:0];
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    b_nxt     = RX_D[WIDTH-1:0];
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_nxt   = RX_D[3:0];
                    state_nxt = ALU_RUN;
                end
            end
            ALU_RUN: begin
                err_nxt   = RX_D_VLD;
                state_nxt = ALU_WAIT;
            end
            ALU_WAIT: begin
                // ALU result is registered one cycle after the enable pulse
                err_nxt    = RX_D_VLD;
                result_nxt = ALU_OUT;
                state_nxt  = SEND_LO;
            end
            SEND_LO: begin
                err_nxt = RX_D_VLD;
                if (TX_RDY) begin
                    state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                err_nxt = RX_D_VLD;
                if (TX_RDY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register so they stay stable through a TX stall
    always_comb begin
        ALU_en   = (state == ALU_RUN);
        TX_D_VLD = (state == SEND_LO) || (state == SEND_HI);
        TX_D     = 8'h00;
        if (state == SEND_LO) begin
            TX_D = result[7:0];
        end else if (state == SEND_HI) begin
            TX_D = result[15:8];
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_D;
    logic        RX_D_VLD;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        ALU_en;
    logic [15:0] ALU_OUT;
    logic [7:0]  TX_D;
    logic        TX_D_VLD;
    logic        TX_RDY;
    logic        CMD_ERR;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          rx_cyc;
    int          first_vld_cyc;
    int          en_cnt;
    int          err_cnt;
    logic        vld_d;
    logic [7:0]  txq[$];

    alu_cmd_ctrl #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_D     (RX_D),
        .RX_D_VLD (RX_D_VLD),
        .A        (A),
        .B        (B),
        .ALU_FUN  (ALU_FUN),
        .ALU_en   (ALU_en),
        .ALU_OUT  (ALU_OUT),
        .TX_D     (TX_D),
        .TX_D_VLD (TX_D_VLD),
        .TX_RDY   (TX_RDY),
        .CMD_ERR  (CMD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU: one-cycle registered latency
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'h0:    return {8'h00, a} + {8'h00, b};
            4'h1:    return {8'h00, a} - {8'h00, b};
            4'h2:    return a * b;
            4'hA:    return (a == b) ? 16'h0001 : 16'h0000;
            4'hF:    return {a, b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) ALU_OUT <= 16'h0000;
        else if (ALU_en) ALU_OUT <= alu_f(A, B, ALU_FUN);
    end

    always @(posedge CLK) cyc++;

    // Monitor: transfers, enable pulses, error pulses, first valid cycle
    always @(negedge CLK) begin
        if (RST) begin
            if (TX_D_VLD && TX_RDY) txq.push_back(TX_D);
            if (ALU_en) en_cnt++;
            if (CMD_ERR) err_cnt++;
            if (TX_D_VLD && !vld_d) first_vld_cyc = cyc;
        end
        vld_d = TX_D_VLD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_D     = b;
        RX_D_VLD = 1'b1;
        rx_cyc   = cyc;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (txq.size() < n && k < 60) begin
            @(negedge CLK);
            k++;
        end
        check("tx_count", txq.size(), n);
    endtask

    task automatic wait_vld();
        int k;
        k = 0;
        while (!TX_D_VLD && k < 30) begin
            @(negedge CLK);
            k++;
        end
        check("vld_seen", TX_D_VLD, 1'b1);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] got;
        wait_tx(2);
        got = 8'h00;
        if (txq.size() > 0) got = txq.pop_front();
        check({tag, "_lo"}, got, lo);
        got = 8'h00;
        if (txq.size() > 0) got = txq.pop_front();
        check({tag, "_hi"}, got, hi);
        repeat (3) @(negedge CLK);
        check({tag, "_extra"}, txq.size(), 0);
    endtask

    initial begin
        int e0;
        int en0;
        n_cmp = 0; n_err = 0; cyc = 0; rx_cyc = 0; first_vld_cyc = 0;
        en_cnt = 0; err_cnt = 0; vld_d = 1'b0;
        RST = 1'b0; RX_D = 8'h00; RX_D_VLD = 1'b0; TX_RDY = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_a", A, 8'h00);
        check("rst_tx_vld", TX_D_VLD, 1'b0);
        check("rst_alu_en", ALU_en, 1'b0);
        check("rst_cmd_err", CMD_ERR, 1'b0);
        RST = 1'b1;

        // CC,05,03,00 -> add: 08,00
        en0 = en_cnt;
        rx_byte(8'hCC); rx_byte(8'h05); rx_byte(8'h03); rx_byte(8'h00);
        expect_tx("add", 8'h08, 8'h00);
        check("add_latency", first_vld_cyc - rx_cyc, 3);
        check("add_en_pulses", en_cnt - en0, 1);
        check("add_fun", ALU_FUN, 4'h0);
        check("add_a", A, 8'h05);
        check("add_b", B, 8'h03);

        // DD,01 reuses A/B -> sub: 02,00
        rx_byte(8'hDD); rx_byte(8'h01);
        expect_tx("reuse", 8'h02, 8'h00);
        check("reuse_a", A, 8'h05);
        check("reuse_b", B, 8'h03);

        // Unknown command byte, then CC,02,02,0A -> equal: 01,00
        e0 = err_cnt; en0 = en_cnt;
        rx_byte(8'h7A);
        repeat (3) @(negedge CLK);
        check("badcmd_err_pulse", err_cnt - e0, 1);
        check("badcmd_no_en", en_cnt - en0, 0);
        rx_byte(8'hCC); rx_byte(8'h02); rx_byte(8'h02); rx_byte(8'h0A);
        expect_tx("cmp", 8'h01, 8'h00);

        // CC,FF,FF,02 with a 5-cycle stall at SEND_LO -> mul: 01,FE
        TX_RDY = 1'b0;
        rx_byte(8'hCC); rx_byte(8'hFF); rx_byte(8'hFF); rx_byte(8'h02);
        wait_vld();
        for (int i = 0; i < 5; i++) begin
            check("stall_d", TX_D, 8'h01);
            check("stall_vld", TX_D_VLD, 1'b1);
            @(negedge CLK);
        end
        TX_RDY = 1'b1;
        expect_tx("mul", 8'h01, 8'hFE);

        // DD,3F: upper nibble ignored, FUN=F passed unchanged -> FF,FF
        rx_byte(8'hDD); rx_byte(8'h3F);
        expect_tx("funf", 8'hFF, 8'hFF);
        check("funf_code", ALU_FUN, 4'hF);

        // Byte 55 while waiting in SEND_LO is dropped
        TX_RDY = 1'b0;
        rx_byte(8'hCC); rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h00);
        wait_vld();
        e0 = err_cnt;
        rx_byte(8'h55);
        repeat (2) @(negedge CLK);
        check("busy_err_pulse", err_cnt - e0, 1);
        check("busy_d", TX_D, 8'h30);
        check("busy_a", A, 8'h10);
        TX_RDY = 1'b1;
        expect_tx("busy", 8'h30, 8'h00);

        // Reset mid-frame after CC,09, then DD,00 on cleared operands
        rx_byte(8'hCC); rx_byte(8'h09);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_a", A, 8'h00);
        check("mid_rst_fun", ALU_FUN, 4'h0);
        check("mid_rst_vld", TX_D_VLD, 1'b0);
        check("mid_rst_d", TX_D, 8'h00);
        @(negedge CLK);
        RST = 1'b1;
        rx_byte(8'hDD); rx_byte(8'h00);
        expect_tx("post_rst", 8'h00, 8'h00);
        check("post_rst_a", A, 8'h00);
        check("post_rst_b", B, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
